// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 opcodes,
// FSM state encodings and operand-signedness helpers.
package muldiv_unit_pkg;

   localparam int REG_DATA_WIDTH = 32;
   localparam int RS_WIDTH       = 5;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      MULDIV_MUL    = 3'b000,
      MULDIV_MULH   = 3'b001,
      MULDIV_MULHSU = 3'b010,
      MULDIV_MULHU  = 3'b011,
      MULDIV_DIV    = 3'b100,
      MULDIV_DIVU   = 3'b101,
      MULDIV_REM    = 3'b110,
      MULDIV_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_CALC = 2'b01,
      MD_DONE = 2'b10
   } md_state_e;

   // MUL's low half is sign-agnostic, so it is treated as unsigned.
   function automatic logic rs1_signed(input logic [2:0] f3);
      return (f3 == MULDIV_MULH) || (f3 == MULDIV_MULHSU) ||
             (f3 == MULDIV_DIV)  || (f3 == MULDIV_REM);
   endfunction

   function automatic logic rs2_signed(input logic [2:0] f3);
      return (f3 == MULDIV_MULH) || (f3 == MULDIV_DIV) || (f3 == MULDIV_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring
// divide over the packed {high, low} accumulator.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   operand,
   output logic [2*XLEN-1:0] acc_next
);

   logic [XLEN:0] sum;
   logic [XLEN:0] trial;

   // Divide keeps {remainder, quotient}; multiply keeps {partial, multiplier}.
   always_comb begin
      sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
      trial = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
      if (is_div) begin
         if (trial[XLEN])
            acc_next = {acc[2*XLEN-2:0], 1'b0};
         else
            acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
         acc_next = {sum, acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with FSM, counter and sign fix-up.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = REG_DATA_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [2:0]          funct3,
   input  logic [XLEN-1:0]     rs1_data,
   input  logic [XLEN-1:0]     rs2_data,
   input  logic [RS_WIDTH-1:0] rd_in,
   input  logic                flush,
   output logic                busy,
   output logic                done,
   output logic [XLEN-1:0]     result,
   output logic [RS_WIDTH-1:0] rd_out,
   output logic                regwrite_out
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e         state, state_next;
   logic [2:0]        op_q;
   logic              neg_res_q, neg_rem_q;
   logic [XLEN-1:0]   operand_q;
   logic [2*XLEN-1:0] acc_q, acc_next;
   logic [CW-1:0]     count_q;

   logic              accept, neg1, neg2, div_zero, div_ovf, fast_mul, fast_path;
   logic [XLEN-1:0]   mag1, mag2, fast_result;

   function automatic logic [XLEN-1:0] fixup(input logic [2:0] op, input logic neg_res,
                                             input logic neg_rem, input logic [2*XLEN-1:0] val);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   quo, rem;
      prod = neg_res ? -val : val;
      quo  = neg_res ? -val[XLEN-1:0] : val[XLEN-1:0];
      rem  = neg_rem ? -val[2*XLEN-1:XLEN] : val[2*XLEN-1:XLEN];
      if (!op[2])
         return (op == MULDIV_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      return op[1] ? rem : quo;
   endfunction

   assign accept   = (state == MD_IDLE) && start && !flush;
   assign neg1     = rs1_signed(funct3) && rs1_data[XLEN-1];
   assign neg2     = rs2_signed(funct3) && rs2_data[XLEN-1];
   assign mag1     = neg1 ? -rs1_data : rs1_data;
   assign mag2     = neg2 ? -rs2_data : rs2_data;
   assign div_zero = funct3[2] && (rs2_data == '0);
   assign div_ovf  = funct3[2] && !funct3[0] && (rs1_data == MIN_INT) && (rs2_data == '1);

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
   assign fast_mul  = !funct3[2];
`else
   assign fast_mul  = 1'b0;
`endif

   assign fast_path = div_zero || div_ovf || fast_mul;

   // Results for ops that complete in a single cycle.
   always_comb begin
      fast_result = '0;
      if (div_zero)
         fast_result = funct3[1] ? rs1_data : {XLEN{1'b1}};
      else if (div_ovf)
         fast_result = funct3[1] ? {XLEN{1'b0}} : MIN_INT;
`ifdef MULDIV_FAST_MUL_EN
      else
         fast_result = fixup(funct3, neg1 ^ neg2, neg1, fast_prod);
`endif
   end

   muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div   (op_q[2]),
      .acc      (acc_q),
      .operand  (operand_q),
      .acc_next (acc_next)
   );

   always_ff @(posedge clk) begin
      if (!rst)
         state <= MD_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         MD_IDLE: if (accept) state_next = fast_path ? MD_DONE : MD_CALC;
         MD_CALC: begin
            if (flush)
               state_next = MD_IDLE;
            else if (count_q == CW'(1))
               state_next = MD_DONE;
         end
         MD_DONE: state_next = MD_IDLE;
         default: state_next = MD_IDLE;
      endcase
   end

   // The last step's output is fixed up directly so the result lands with DONE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         result    <= '0;
         rd_out    <= '0;
         count_q   <= '0;
         acc_q     <= '0;
         operand_q <= '0;
         op_q      <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (accept) begin
                  op_q      <= funct3;
                  rd_out    <= rd_in;
                  neg_res_q <= neg1 ^ neg2;
                  neg_rem_q <= neg1;
                  operand_q <= mag2;
                  acc_q     <= {{XLEN{1'b0}}, mag1};
                  count_q   <= CW'(XLEN);
                  if (fast_path)
                     result <= fast_result;
               end
            end
            MD_CALC: begin
               if (!flush) begin
                  acc_q   <= acc_next;
                  count_q <= count_q - CW'(1);
                  if (count_q == CW'(1))
                     result <= fixup(op_q, neg_res_q, neg_rem_q, acc_next);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy         = (state == MD_CALC) || accept;
   assign done         = (state == MD_DONE);
   assign regwrite_out = done && (rd_out != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; latency expectations follow
// MULDIV_FAST_MUL_EN when it is defined for the build.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic [4:0]  rd_in = '0;
   logic        flush = 1'b0;
   logic        busy, done, regwrite_out;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int checks   = 0;
   int failures = 0;

   muldiv_unit dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .funct3       (funct3),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .rd_in        (rd_in),
      .flush        (flush),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .rd_out       (rd_out),
      .regwrite_out (regwrite_out)
   );

   always #5 clk = ~clk;

   // Present an instruction and let the issue edge sample it.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      funct3   = f3;
      rs1_data = a;
      rs2_data = b;
      rd_in    = rd;
      start    = 1'b1;
      @(posedge clk); #1;
   endtask

   // Cycle 1 is the period right after the issue edge; cyc stays 0 on timeout.
   task automatic wait_done(output int cyc, output logic busy_ok);
      cyc     = 0;
      busy_ok = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         if (done === 1'b1) begin
            cyc = c;
            if (busy !== 1'b0) busy_ok = 1'b0;
            break;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic retire();
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (result !== 32'h0) begin failures++; $display("[TB] FAIL reset_result: got %h want 00000000", result); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if (rd_out !== 5'd0) begin failures++; $display("[TB] FAIL reset_rd_out: got %0d want 0", rd_out); end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      int cyc; logic bok;
      issue(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
      wait_done(cyc, bok);
      checks++; if (cyc !== MUL_LAT) begin failures++; $display("[TB] FAIL mul_latency: got %0d want %0d", cyc, MUL_LAT); end
      checks++; if (bok !== 1'b1) begin failures++; $display("[TB] FAIL mul_busy: got %b want 1", bok); end
      checks++; if (result !== 32'hFFFF_FFEB) begin failures++; $display("[TB] FAIL mul_result: got %h want ffffffeb", result); end
      checks++; if (rd_out !== 5'd5) begin failures++; $display("[TB] FAIL mul_rd_out: got %0d want 5", rd_out); end
      checks++; if (regwrite_out !== 1'b1) begin failures++; $display("[TB] FAIL mul_regwrite: got %b want 1", regwrite_out); end
      retire();
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL mul_done_pulse: got %b want 0", done); end
      checks++; if (result !== 32'hFFFF_FFEB) begin failures++; $display("[TB] FAIL mul_hold: got %h want ffffffeb", result); end
   endtask

   task automatic test_mulh();
      logic [2:0]  ops [3];
      logic [31:0] exp_v [3];
      int cyc; logic bok;
      ops   = '{3'b001, 3'b011, 3'b010};
      exp_v = '{32'h4000_0000, 32'h4000_0000, 32'hC000_0000};
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], 32'h8000_0000, 32'h8000_0000, 5'd7);
         wait_done(cyc, bok);
         checks++; if (cyc !== MUL_LAT) begin failures++; $display("[TB] FAIL mulh_latency[%0d]: got %0d want %0d", i, cyc, MUL_LAT); end
         checks++; if (result !== exp_v[i]) begin failures++; $display("[TB] FAIL mulh_result[%0d]: got %h want %h", i, result, exp_v[i]); end
         retire();
      end
   endtask

   task automatic test_div();
      logic [2:0]  ops [3];
      logic [31:0] a_v [3];
      logic [31:0] b_v [3];
      logic [31:0] exp_v [3];
      int cyc; logic bok;
      ops   = '{3'b100, 3'b110, 3'b101};
      a_v   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
      b_v   = '{32'h2, 32'h2, 32'h2};
      exp_v = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], a_v[i], b_v[i], 5'd9);
         wait_done(cyc, bok);
         checks++; if (cyc !== DIV_LAT) begin failures++; $display("[TB] FAIL div_latency[%0d]: got %0d want %0d", i, cyc, DIV_LAT); end
         checks++; if (bok !== 1'b1) begin failures++; $display("[TB] FAIL div_busy[%0d]: got %b want 1", i, bok); end
         checks++; if (result !== exp_v[i]) begin failures++; $display("[TB] FAIL div_result[%0d]: got %h want %h", i, result, exp_v[i]); end
         retire();
      end
   endtask

   task automatic test_div_special();
      logic [2:0]  ops [4];
      logic [31:0] a_v [4];
      logic [31:0] b_v [4];
      logic [31:0] exp_v [4];
      int cyc; logic bok;
      ops   = '{3'b100, 3'b111, 3'b100, 3'b110};
      a_v   = '{32'h5, 32'h5, 32'h8000_0000, 32'h8000_0000};
      b_v   = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      exp_v = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], a_v[i], b_v[i], 5'd11);
         wait_done(cyc, bok);
         checks++; if (cyc !== 1) begin failures++; $display("[TB] FAIL special_latency[%0d]: got %0d want 1", i, cyc); end
         checks++; if (result !== exp_v[i]) begin failures++; $display("[TB] FAIL special_result[%0d]: got %h want %h", i, result, exp_v[i]); end
         retire();
      end
   endtask

   task automatic test_flush();
      logic [31:0] old;
      int pulses;
      old = result;
      flush = 1'b1;
      funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd3; start = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle_busy: got %b want 0", busy); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle_accept: got %b want 0", busy); end
      flush = 1'b0;
      issue(3'b101, 32'd100, 32'd7, 5'd3);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      start = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_calc_busy: got %b want 0", busy); end
      flush = 1'b0;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         if (done === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      checks++; if (pulses !== 0) begin failures++; $display("[TB] FAIL flush_no_done: got %0d pulses want 0", pulses); end
      checks++; if (result !== old) begin failures++; $display("[TB] FAIL flush_result: got %h want %h", result, old); end
   endtask

   task automatic test_reset_mid();
      int cyc; logic bok;
      issue(3'b100, 32'd1000, 32'd3, 5'd4);
      repeat (19) @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      checks++; if (result !== 32'h0) begin failures++; $display("[TB] FAIL midrst_result: got %h want 00000000", result); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done: got %b want 0", done); end
      rst = 1'b1;
      @(posedge clk); #1;
      issue(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd6);
      wait_done(cyc, bok);
      checks++; if (cyc !== DIV_LAT) begin failures++; $display("[TB] FAIL postrst_latency: got %0d want %0d", cyc, DIV_LAT); end
      checks++; if (result !== 32'hFFFF_FFF2) begin failures++; $display("[TB] FAIL postrst_result: got %h want fffffff2", result); end
      retire();
   endtask

   task automatic test_back_to_back();
      int cyc; logic bok;
      issue(3'b000, 32'd3, 32'd4, 5'd0);
      wait_done(cyc, bok);
      checks++; if (cyc !== MUL_LAT) begin failures++; $display("[TB] FAIL x0_latency: got %0d want %0d", cyc, MUL_LAT); end
      checks++; if (result !== 32'h0000_000C) begin failures++; $display("[TB] FAIL x0_result: got %h want 0000000c", result); end
      checks++; if (regwrite_out !== 1'b0) begin failures++; $display("[TB] FAIL x0_regwrite: got %b want 0", regwrite_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL x0_done_busy: got %b want 0", busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_gap_done: got %b want 0", done); end
      issue(3'b000, 32'd6, 32'd7, 5'd3);
      wait_done(cyc, bok);
      checks++; if (cyc !== MUL_LAT) begin failures++; $display("[TB] FAIL b2b_latency: got %0d want %0d", cyc, MUL_LAT); end
      checks++; if (result !== 32'd42) begin failures++; $display("[TB] FAIL b2b_result: got %h want 0000002a", result); end
      checks++; if (regwrite_out !== 1'b1) begin failures++; $display("[TB] FAIL b2b_regwrite: got %b want 1", regwrite_out); end
      retire();
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_div_special();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the register file. It consumes the two register read ports, computes one RV32M result over several cycles, and stalls the core while it works. It hands the result, destination register and write enable back to the register-file write port. Ordinary ALU ops bypass it; the decoder asserts `start` only for OP-with-funct7=0000001.

## Interface
Parameters:
- `XLEN`, default `REG_DATA_WIDTH` (32): operand and result width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset; effective only at a rising edge while low.
- `start`  in  1  M-extension instruction present; held high by core while stalled.
- `funct3`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data`  in  XLEN  from register-file `read_data1`.
- `rs2_data`  in  XLEN  from register-file `read_data2`.
- `rd_in`  in  `RS_WIDTH`  destination register.
- `flush`  in  1  abort current operation.
- `busy`  out  1  stall request to PC/control (combinational).
- `done`  out  1  one-cycle pulse; result valid.
- `result`  out  XLEN  registered result, held until next accept.
- `rd_out`  out  `RS_WIDTH`  latched destination.
- `regwrite_out`  out  1  `done & (rd_out != 0)`.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start=1` accepts: latch funct3, rd, sign flags, operand magnitudes (signed ops only), and load counter with XLEN.
  - Fast path goes IDLE→DONE directly for: divide by zero, signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF), and MUL* when `MULDIV_FAST_MUL_EN` is defined.
  - All other ops go IDLE→CALC.
- CALC: one step per cycle; counter decrements; at counter==1 the next edge applies sign fix-up, writes `result`, and goes →DONE.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per step.
- DONE: `done=1` for exactly one cycle, then →IDLE unconditionally. `start` is ignored in DONE; that start belongs to the retiring instruction.
- Results:
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half; product is negated if the operand signs differ.
  - DIV negates the quotient if the signs differ.
  - REM takes the dividend's sign.
- Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
- Overflow: DIV returns 0x80000000; REM returns 0.
- `flush`: in CALC, goes →IDLE next edge with no `done` and `result` unchanged. In IDLE it suppresses accept. In DONE it has no effect.
- `rst` low: →IDLE, `result=0`, `rd_out=0`, `done=0`, counter 0, from any state, including mid-CALC.

## Timing
- `busy = (state==CALC) | (state==IDLE & start & ~flush)`; `busy` is low in DONE.
- Issue edge is cycle 0:
  - Iterative ops: CALC occupies cycles 1..XLEN, DONE is cycle XLEN+1 (33 for XLEN=32). Total stall is XLEN+1 cycles.
  - Fast-path ops: DONE is cycle 1; stall is 1 cycle.
- Back-to-back M instructions: the second is accepted the cycle after DONE (one IDLE cycle); there is no overlap.
- Register-file write occurs at the DONE-cycle edge through `regwrite_out`. When `rd_in` is x0, `done` still pulses but `regwrite_out` stays 0.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MUL* ops use a single combinational XLEN×XLEN multiplier and take the fast path (latency 1). Division remains iterative.
- Undefined: all MUL* ops are iterative (latency XLEN+1) and no `*` operator is inferred.

## Structure
- Add to `riscv_def.v`:
  - funct3 constants `MULDIV_MUL` … `MULDIV_REMU`;
  - `FUNCT7_MULDIV` (7'b0000001);
  - state encodings `MD_IDLE`, `MD_CALC`, `MD_DONE`.
- One sub-module, `muldiv_step`: combinational single-iteration datapath (shift-add or restoring subtract) for the current accumulator, remainder and quotient. The FSM, counter and sign fix-up stay in `muldiv_unit`.

## Test plan
- MUL 7×−3: rs1=0x00000007, rs2=0xFFFFFFFD → `result` 0xFFFFFFEB. `done` at cycle 33 (cycle 1 with fast mul); `busy` high until then.
- MULH/MULHU/MULHSU 0x80000000×0x80000000 → 0x40000000 / 0x40000000 / 0xC0000000 respectively.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF.
- Divide by zero:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 0x00000005; `done` at cycle 1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 at cycle 1.
- Abort and reset:
  - `flush` at cycle 10 of DIVU → IDLE, no `done`, `result` keeps its old value.
  - `rst` low at cycle 20 → `result=0`, `busy=0` next cycle.
  - A new DIV accepted afterwards completes correctly.
- `rd_in`=0 MUL 3×4 → `done` pulses with `result` 0x0000000C and `regwrite_out`=0. `start` held high through DONE is not re-accepted, and `busy` stays low that cycle.
